gb_cart_responder: RTL

Cartridge-side responder for the Game Boy external bus: the DUT console is the bus initiator, and this block answers it as a cartridge would. ROM-space reads are served from the device-under-test RAM. Every bus write to ROM or XRAM space is captured as a 4-byte event into the recording RAM for readback by the LR35902 system CPU. It sits in the top level between the cartridge-bus SB_IO pins and the dutram/recram block RAMs, clocked by cpuclk.

---
 rtl/gb_cart_responder.sv | 310 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/gb_cart_responder.sv
// gb_cart_responder
// Cartridge-side responder for the Game Boy external bus. The console drives
// the bus; this block answers ROM-space reads from the DUT RAM and records
// every ROM/XRAM write as a 4-byte event {adr lo, {cs_xram, adr hi}, data,
// phi timestamp} into the recording RAM.
//
// Ports
//   clk, reset            cpuclk, asynchronous active-high reset
//   bus_*                 raw cartridge bus pins (address, strobes, phi, data in)
//   bus_data_out/_oe      data driven back onto the bus and its output enable
//   mem_adr/mem_rd/mem_din  DUT RAM read port (data one cycle after mem_rd)
//   rec_adr/rec_data/rec_wr recording RAM write port
//   rec_enable/rec_clear  capture enable and one-cycle buffer clear
//   rec_count/rec_overflow  bytes recorded and sticky dropped-event flag
module gb_cart_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int REC_AW      = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [14:0]       bus_adr,
    input  logic              bus_n_rd,
    input  logic              bus_n_wr,
    input  logic              bus_n_cs_rom,
    input  logic              bus_n_cs_xram,
    input  logic              bus_phi,
    input  logic [7:0]        bus_data_in,
    output logic [7:0]        bus_data_out,
    output logic              bus_data_oe,
    output logic [11:0]       mem_adr,
    output logic              mem_rd,
    input  logic [7:0]        mem_din,
    output logic [REC_AW-1:0] rec_adr,
    output logic [7:0]        rec_data,
    output logic              rec_wr,
    input  logic              rec_enable,
    input  logic              rec_clear,
    output logic [REC_AW:0]   rec_count,
    output logic              rec_overflow
);

    // Packed bus sample: {phi, n_cs_xram, n_cs_rom, n_wr, n_rd, data[7:0], adr[14:0]}
    localparam int BW = 28;

    // Highest write pointer that still leaves room for a full 4-byte event
    localparam logic [REC_AW:0] REC_CAP   = {1'b1, {REC_AW{1'b0}}};
    localparam logic [REC_AW:0] REC_LIMIT = REC_CAP - (REC_AW+1)'(3'd4);
    localparam logic [REC_AW:0] PTR_ONE   = {{REC_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRIVE   = 3'd2,
        S_WR_WAIT = 3'd3,
        S_LOG0    = 3'd4,
        S_LOG1    = 3'd5,
        S_LOG2    = 3'd6,
        S_LOG3    = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0][BW-1:0] sync_q, sync_d;
    logic              n_wr_dly_q, n_wr_dly_d;
    logic              phi_dly_q, phi_dly_d;
    state_t            state_q, state_d;
    logic [14:0]       lat_adr_q, lat_adr_d;
    logic              cs_xram_q, cs_xram_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        ts_q, ts_d;
    logic [7:0]        ts_lat_q, ts_lat_d;
    logic [REC_AW:0]   wr_ptr_q, wr_ptr_d;
    logic              ovf_q, ovf_d;
    logic              oe_q, oe_d;
    logic [7:0]        dout_q, dout_d;
    logic              mem_rd_q, mem_rd_d;
    logic [11:0]       mem_adr_q, mem_adr_d;
    logic              rec_wr_q, rec_wr_d;
    logic [REC_AW-1:0] rec_adr_q, rec_adr_d;
    logic [7:0]        rec_data_q, rec_data_d;

    logic [BW-1:0] raw_s;
    logic [BW-1:0] cur_s;
    logic [BW-1:0] pre_s;
    logic [14:0]   adr_s;
    logic [7:0]    data_s;
    logic          n_rd_s, n_wr_s, n_cs_rom_s, n_cs_xram_s, phi_s;
    logic          rd_req_s, wr_fall_s, wr_rise_s, phi_rise_s, room_s;
    logic [14:0]   p_adr_s;
    logic          p_rd_req_s, p_wr_fall_s;

    assign raw_s = {bus_phi, bus_n_cs_xram, bus_n_cs_rom, bus_n_wr, bus_n_rd, bus_data_in, bus_adr};

    // cur_s is the fully synchronised view; pre_s is what cur_s becomes next cycle
    assign cur_s = sync_q[SYNC_STAGES-1];
    assign pre_s = sync_q[SYNC_STAGES-2];

    assign adr_s       = cur_s[14:0];
    assign data_s      = cur_s[22:15];
    assign n_rd_s      = cur_s[23];
    assign n_wr_s      = cur_s[24];
    assign n_cs_rom_s  = cur_s[25];
    assign n_cs_xram_s = cur_s[26];
    assign phi_s       = cur_s[27];

    assign rd_req_s   = !n_rd_s && !n_cs_rom_s && n_wr_s;
    assign wr_fall_s  = !n_wr_s && n_wr_dly_q && (!n_cs_rom_s || !n_cs_xram_s);
    assign wr_rise_s  = n_wr_s && !n_wr_dly_q;
    assign phi_rise_s = phi_s && !phi_dly_q;

    // Look-ahead versions let mem_rd/mem_adr be registered yet land in the
    // same cycle the FSM acts on the synchronised request.
    assign p_adr_s     = pre_s[14:0];
    assign p_rd_req_s  = !pre_s[23] && !pre_s[25] && pre_s[24];
    assign p_wr_fall_s = !pre_s[24] && n_wr_s && (!pre_s[25] || !pre_s[26]);

    // Synchroniser shift chain and edge-detect delay flops
    always_comb begin
        sync_d[0] = raw_s;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        n_wr_dly_d = n_wr_s;
        phi_dly_d  = phi_s;
    end

    // Bus FSM, timestamp counter and record-buffer bookkeeping
    always_comb begin
        state_d    = state_q;
        lat_adr_d  = lat_adr_q;
        cs_xram_d  = cs_xram_q;
        wr_data_d  = wr_data_q;
        ts_lat_d   = ts_lat_q;
        oe_d       = oe_q;
        dout_d     = dout_q;
        ovf_d      = ovf_q;
        rec_wr_d   = 1'b0;
        rec_adr_d  = rec_adr_q;
        rec_data_d = rec_data_q;

        if (phi_rise_s) begin
            ts_d = ts_q + 8'd1;
        end else begin
            ts_d = ts_q;
        end

        // Clear applies first so every state below sees the post-clear pointer
        if (rec_clear) begin
            wr_ptr_d = {(REC_AW+1){1'b0}};
            ovf_d    = 1'b0;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        room_s = (wr_ptr_d <= REC_LIMIT);

        case (state_q)
            S_IDLE: begin
                oe_d = 1'b0;
                if (wr_fall_s) begin
                    state_d   = S_WR_WAIT;
                    lat_adr_d = adr_s;
                    cs_xram_d = !n_cs_xram_s;
                    ts_lat_d  = ts_q;
                    wr_data_d = data_s;
                end else if (rd_req_s) begin
                    state_d   = S_FETCH;
                    lat_adr_d = adr_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_DRIVE;
                dout_d  = mem_din;
                oe_d    = 1'b1;
            end
            S_DRIVE: begin
                if (!rd_req_s) begin
                    state_d = S_IDLE;
                    oe_d    = 1'b0;
                end else if (adr_s != lat_adr_q) begin
                    state_d   = S_FETCH;
                    lat_adr_d = adr_s;
                    oe_d      = 1'b0;
                end else begin
                    oe_d = 1'b1;
                end
            end
            S_WR_WAIT: begin
                // On the rising edge the sample from the previous cycle is kept:
                // it is the last value seen while n_wr was still low.
                if (wr_rise_s) begin
                    if (rec_enable && room_s) begin
                        state_d    = S_LOG0;
                        rec_wr_d   = 1'b1;
                        rec_adr_d  = wr_ptr_d[REC_AW-1:0];
                        rec_data_d = lat_adr_q[7:0];
                    end else begin
                        state_d = S_IDLE;
                        if (rec_enable && !rec_clear) begin
                            ovf_d = 1'b1;
                        end else begin
                            ovf_d = ovf_d;
                        end
                    end
                end else begin
                    wr_data_d = data_s;
                end
            end
            S_LOG0, S_LOG1, S_LOG2: begin
                if (rec_clear) begin
                    state_d = S_IDLE;
                end else begin
                    wr_ptr_d  = wr_ptr_q + PTR_ONE;
                    rec_wr_d  = 1'b1;
                    rec_adr_d = wr_ptr_d[REC_AW-1:0];
                    case (state_q)
                        S_LOG0: begin
                            state_d    = S_LOG1;
                            rec_data_d = {cs_xram_q, lat_adr_q[14:8]};
                        end
                        S_LOG1: begin
                            state_d    = S_LOG2;
                            rec_data_d = wr_data_q;
                        end
                        default: begin
                            state_d    = S_LOG3;
                            rec_data_d = ts_lat_q;
                        end
                    endcase
                end
            end
            S_LOG3: begin
                state_d = S_IDLE;
                if (rec_clear) begin
                    wr_ptr_d = wr_ptr_d;
                end else begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                oe_d    = 1'b0;
            end
        endcase

        // Strobe the DUT RAM in the cycle the FSM will take a FETCH decision
        mem_adr_d = p_adr_s[11:0];
        if (p_rd_req_s && (state_d == S_IDLE) && !p_wr_fall_s) begin
            mem_rd_d = 1'b1;
        end else if (p_rd_req_s && (state_d == S_DRIVE) && (p_adr_s != lat_adr_d)) begin
            mem_rd_d = 1'b1;
        end else begin
            mem_rd_d = 1'b0;
        end
    end

    // State register; sync flops reset to the idle-high bus level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= {(SYNC_STAGES*BW){1'b1}};
            n_wr_dly_q <= 1'b1;
            phi_dly_q  <= 1'b1;
            state_q    <= S_IDLE;
            lat_adr_q  <= 15'd0;
            cs_xram_q  <= 1'b0;
            wr_data_q  <= 8'd0;
            ts_q       <= 8'd0;
            ts_lat_q   <= 8'd0;
            wr_ptr_q   <= {(REC_AW+1){1'b0}};
            ovf_q      <= 1'b0;
            oe_q       <= 1'b0;
            dout_q     <= 8'hff;
            mem_rd_q   <= 1'b0;
            mem_adr_q  <= 12'd0;
            rec_wr_q   <= 1'b0;
            rec_adr_q  <= {REC_AW{1'b0}};
            rec_data_q <= 8'd0;
        end else begin
            sync_q     <= sync_d;
            n_wr_dly_q <= n_wr_dly_d;
            phi_dly_q  <= phi_dly_d;
            state_q    <= state_d;
            lat_adr_q  <= lat_adr_d;
            cs_xram_q  <= cs_xram_d;
            wr_data_q  <= wr_data_d;
            ts_q       <= ts_d;
            ts_lat_q   <= ts_lat_d;
            wr_ptr_q   <= wr_ptr_d;
            ovf_q      <= ovf_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            mem_rd_q   <= mem_rd_d;
            mem_adr_q  <= mem_adr_d;
            rec_wr_q   <= rec_wr_d;
            rec_adr_q  <= rec_adr_d;
            rec_data_q <= rec_data_d;
        end
    end

    assign bus_data_oe  = oe_q;
    assign bus_data_out = dout_q;
    assign mem_adr      = mem_adr_q;
    assign mem_rd       = mem_rd_q;
    assign rec_adr      = rec_adr_q;
    assign rec_data     = rec_data_q;
    // A clear arriving mid-event must stop the byte already queued for this cycle
    assign rec_wr       = rec_wr_q && !rec_clear;
    assign rec_count    = wr_ptr_q;
    assign rec_overflow = ovf_q;

endmodule
